// File: rtl/d_mem_port_wb.sv
// Data-side MEM-stage port to the SRAM-like req/addr_ok/data_ok bus, with a posted-store write buffer.
// Optional DSRAM_PERF_CNT_EN adds request and stall performance counters.
module d_mem_port_wb #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WB_DEPTH = 2,
  parameter int EXC_W    = 5,
  localparam int CNT_W   = $clog2(WB_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                memenM,
  input  logic                memwriteM,
  input  logic [DATA_W/8-1:0] sel,
  input  logic [1:0]          data_sram_size,
  input  logic [ADDR_W-1:0]   aluoutM,
  input  logic [DATA_W-1:0]   writedata2M,
  input  logic                flushM,
  input  logic [EXC_W-1:0]    tlb_exceptM,
  input  logic                data_found,
  input  logic                data_V_flag,
  input  logic                data_D_flag,
  output logic [EXC_W-1:0]    tlb_except2M,
  output logic                stallM,
  output logic [DATA_W-1:0]   readdataM,
  output logic                data_req,
  output logic                data_wr,
  output logic [DATA_W/8-1:0] data_wen,
  output logic [1:0]          data_size,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W-1:0]   data_rdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  output logic [1:0]          state_dbg,
  output logic [CNT_W-1:0]    pend_dbg
`ifdef DSRAM_PERF_CNT_EN
  ,
  output logic [31:0]         perf_req_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  // Handshake: a bus request is taken on any cycle where data_req & data_addr_ok;
  // responses arrive in order as single-cycle data_ok pulses with data_rdata valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    LWAIT = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WB_MAX = CNT_W'(WB_DEPTH);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    pend_q;
  logic [DATA_W-1:0]   rdata_q;

  logic exc;
  logic live;
  logic req_phase;
  logic room;
  logic accept;
  logic store_acc;
  logic load_acc;
  logic load_done;
  logic pend_inc;
  logic pend_dec;

  // TLB fault merge: miss beats invalid beats modify.
  always_comb begin
    tlb_except2M = tlb_exceptM;
    if (memenM & ~data_found) begin
      tlb_except2M[2]   = 1'b1;
      tlb_except2M[1:0] = 2'b00;
    end else if (memenM & data_found & ~data_V_flag) begin
      tlb_except2M[1] = 1'b1;
      tlb_except2M[0] = 1'b0;
    end else if (data_found & data_V_flag & memwriteM & ~data_D_flag) begin
      tlb_except2M[0] = 1'b1;
    end
  end

  assign exc       = memenM & (|tlb_except2M);
  assign live      = memenM & ~exc & ~flushM;
  assign req_phase = (state_q == IDLE) || (state_q == REQ);
  // Stores may post while the buffer has room; loads wait for it to drain so their data_ok is unambiguous.
  assign room      = memwriteM ? (pend_q < WB_MAX) : (pend_q == '0);

  assign data_req  = rst & req_phase & live & room;
  assign accept    = data_req & data_addr_ok;
  assign store_acc = accept & memwriteM;
  assign load_acc  = accept & ~memwriteM;
  assign load_done = (state_q == LWAIT) & data_data_ok;

  assign stallM    = rst & live & ~store_acc & ~load_done;
  assign readdataM = load_done ? data_rdata : rdata_q;

  assign data_wr    = memwriteM;
  assign data_wen   = sel;
  assign data_size  = data_sram_size;
  assign data_addr  = aluoutM;
  assign data_wdata = writedata2M;

  assign state_dbg = state_q;
  assign pend_dbg  = pend_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, REQ: begin
        if (load_acc)               state_d = LWAIT;
        else if (live & ~store_acc) state_d = REQ;
        else                        state_d = IDLE;
      end
      LWAIT: begin
        if (data_data_ok)  state_d = IDLE;
        else if (flushM)   state_d = DRAIN;
      end
      DRAIN: begin
        if (data_data_ok)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // data_ok seen in LWAIT/DRAIN belongs to the load, never to a posted store.
  assign pend_inc = store_acc;
  assign pend_dec = data_data_ok & req_phase & (pend_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (pend_inc & ~pend_dec)      pend_q <= pend_q + CNT_W'(1);
      else if (~pend_inc & pend_dec) pend_q <= pend_q - CNT_W'(1);
      if (load_done) rdata_q <= data_rdata;
    end
  end

`ifdef DSRAM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_req_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (accept) perf_req_cnt   <= perf_req_cnt + 32'd1;
      if (stallM) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_d_mem_port_wb.sv
// Bench for d_mem_port_wb: directed bus scenarios, then random ops against a word-memory reference model.
module tb_d_mem_port_wb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WB = 2;
  localparam int EW = 5;
  localparam int CW = $clog2(WB + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          memenM, memwriteM, flushM;
  logic [3:0]    sel;
  logic [1:0]    data_sram_size;
  logic [AW-1:0] aluoutM;
  logic [DW-1:0] writedata2M;
  logic [EW-1:0] tlb_exceptM;
  logic          data_found, data_V_flag, data_D_flag;
  logic [EW-1:0] tlb_except2M;
  logic          stallM;
  logic [DW-1:0] readdataM;
  logic          data_req, data_wr;
  logic [3:0]    data_wen;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          data_addr_ok, data_data_ok;
  logic [1:0]    state_dbg;
  logic [CW-1:0] pend_dbg;

  // Bus responder: either scripted (directed tests) or a random in-order slave.
  bit            auto_bus = 1'b0;
  logic          man_aok = 1'b0, man_dok = 1'b0;
  logic [DW-1:0] man_rdata = '0;
  logic          auto_aok = 1'b0, auto_dok = 1'b0;
  logic [DW-1:0] auto_rdata = '0;
  assign data_addr_ok = auto_bus ? auto_aok   : man_aok;
  assign data_data_ok = auto_bus ? auto_dok   : man_dok;
  assign data_rdata   = auto_bus ? auto_rdata : man_rdata;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_q[$];
  bit            chk_load = 1'b0;

  logic [DW-1:0] ref_mem[16];
  logic [DW-1:0] bus_mem[16];
  bit            bq_ld[$];
  logic [DW-1:0] bq_dat[$];

  d_mem_port_wb #(.ADDR_W(AW), .DATA_W(DW), .WB_DEPTH(WB), .EXC_W(EW)) dut (
    .clk(clk), .rst(rst), .memenM(memenM), .memwriteM(memwriteM), .sel(sel),
    .data_sram_size(data_sram_size), .aluoutM(aluoutM), .writedata2M(writedata2M),
    .flushM(flushM), .tlb_exceptM(tlb_exceptM), .data_found(data_found),
    .data_V_flag(data_V_flag), .data_D_flag(data_D_flag), .tlb_except2M(tlb_except2M),
    .stallM(stallM), .readdataM(readdataM), .data_req(data_req), .data_wr(data_wr),
    .data_wen(data_wen), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .state_dbg(state_dbg), .pend_dbg(pend_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] exp_tlb(input bit men, input bit wr, input bit f,
                                            input bit v, input bit d, input logic [EW-1:0] ein);
    logic [EW-1:0] r;
    r = ein;
    if (men && !f) begin
      r[2] = 1'b1; r[1:0] = 2'b00;
    end else if (men && f && !v) begin
      r[1] = 1'b1; r[0] = 1'b0;
    end else if (f && v && wr && !d) begin
      r[0] = 1'b1;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input bit wr, input logic [31:0] addr, input logic [3:0] s,
                        input logic [31:0] wd, input bit f, input bit v, input bit d,
                        input logic [EW-1:0] ein);
    memenM = 1'b1; memwriteM = wr; aluoutM = addr; sel = s; writedata2M = wd;
    data_found = f; data_V_flag = v; data_D_flag = d; tlb_exceptM = ein;
    data_sram_size = 2'd2;
  endtask

  // Scoreboard monitor: a live load with stall released presents its data.
  always @(negedge clk) begin
    if (rst && chk_load && !stallM) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL load_data: no expected entry, got %h", readdataM);
      end else begin
        chk("load_data", readdataM, exp_q.pop_front());
      end
    end
  end

  // Random slave: bookkeeping and request-ordering checks at the sampling edge.
  always @(negedge clk) begin
    if (auto_bus && rst) begin
      if (data_req) begin
        bit has_ld;
        has_ld = 1'b0;
        foreach (bq_ld[i]) if (bq_ld[i]) has_ld = 1'b1;
        chk("req_order", {31'd0, !has_ld && (memwriteM ? bq_ld.size() < WB : bq_ld.size() == 0)}, 32'd1);
        chk("bus_addr", data_addr, aluoutM);
      end
      if (data_req && data_addr_ok) begin
        if (data_wr) begin
          for (int b = 0; b < 4; b++)
            if (data_wen[b]) bus_mem[data_addr[5:2]][8*b +: 8] = data_wdata[8*b +: 8];
          bq_ld.push_back(1'b0);
          bq_dat.push_back($urandom);
        end else begin
          bq_ld.push_back(1'b1);
          bq_dat.push_back(bus_mem[data_addr[5:2]]);
        end
      end
      if (data_data_ok && bq_ld.size() > 0) begin
        void'(bq_ld.pop_front());
        void'(bq_dat.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    auto_aok = ($urandom_range(0, 3) != 0);
    if (bq_ld.size() > 0 && $urandom_range(0, 2) != 0) begin
      auto_dok = 1'b1; auto_rdata = bq_dat[0];
    end else begin
      auto_dok = 1'b0; auto_rdata = $urandom;
    end
  end

  task automatic run_op(input bit wr, input int idx, input logic [3:0] s, input logic [31:0] wd,
                        input bit f, input bit v, input bit d, input logic [EW-1:0] ein);
    logic [EW-1:0] et;
    int budget;
    et = exp_tlb(1'b1, wr, f, v, d, ein);
    set_op(wr, 32'h8000_0000 + 32'(idx) * 4, s, wd, f, v, d, ein);
    data_sram_size = 2'($urandom_range(0, 2));
    if (et != '0) begin
      @(negedge clk);
      chk("tlb_vec", 32'(tlb_except2M), 32'(et));
      chk("exc_quiet", {30'd0, stallM, data_req}, 32'd0);
    end else begin
      if (wr) begin
        for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_q.push_back(ref_mem[idx]);
        chk_load = 1'b1;
      end
      budget = 0;
      @(negedge clk);
      while (stallM && budget < 200) begin
        step();
        @(negedge clk);
        budget++;
      end
      if (stallM) begin
        checks++; errors++;
        $display("FAIL op_timeout: stallM still 1 after %0d cycles", budget);
      end
    end
    step();
    chk_load = 1'b0;
    memenM = 1'b0;
  endtask

  bit            tm_men[6]  = '{1, 1, 1, 0, 0, 1};
  bit            tm_wr[6]   = '{0, 1, 0, 1, 0, 1};
  bit            tm_f[6]    = '{0, 1, 1, 1, 0, 0};
  bit            tm_v[6]    = '{1, 1, 0, 1, 0, 0};
  bit            tm_d[6]    = '{1, 0, 1, 0, 0, 0};
  logic [EW-1:0] tm_ein[6]  = '{5'b00011, 5'b00000, 5'b10001, 5'b00000, 5'b01000, 5'b00000};

  initial begin
    int budget;
    rst = 1'b0; flushM = 1'b0;
    set_op(1'b0, 32'h8000_0000, 4'hF, '0, 1'b1, 1'b1, 1'b1, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, stallM}, 32'd0);
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_rdata", readdataM, 32'd0);
    chk("rst_pend", 32'(pend_dbg), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    step(); memenM = 1'b0; rst = 1'b1;

    // Single load: addr_ok at cycle 1, data_ok at cycle 3.
    step();
    set_op(1'b0, 32'h8000_0010, 4'hF, '0, 1'b1, 1'b1, 1'b1, '0);
    exp_q.push_back(32'hDEAD_BEEF); chk_load = 1'b1;
    @(negedge clk); chk("ld_c0_req", {31'd0, data_req}, 32'd1); chk("ld_c0_stall", {31'd0, stallM}, 32'd1);
    step(); man_aok = 1'b1;
    @(negedge clk); chk("ld_c1_req", {31'd0, data_req}, 32'd1); chk("ld_c1_stall", {31'd0, stallM}, 32'd1);
    step(); man_aok = 1'b0;
    @(negedge clk); chk("ld_c2_req", {31'd0, data_req}, 32'd0); chk("ld_c2_stall", {31'd0, stallM}, 32'd1);
    step(); man_dok = 1'b1; man_rdata = 32'hDEAD_BEEF;
    @(negedge clk); chk("ld_c3_stall", {31'd0, stallM}, 32'd0);
    step(); chk_load = 1'b0; memenM = 1'b0; man_dok = 1'b0; man_rdata = '0;
    @(negedge clk); chk("ld_hold", readdataM, 32'hDEAD_BEEF); chk("ld_idle", 32'(state_dbg), 32'd0);

    // Three back-to-back stores, buffer depth 2.
    man_aok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(); set_op(1'b1, 32'h8000_0000 + 32'(i) * 4, 4'hF, 32'(i), 1'b1, 1'b1, 1'b1, '0);
      @(negedge clk); chk("st_req", {31'd0, data_req}, 32'd1); chk("st_nostall", {31'd0, stallM}, 32'd0);
    end
    step(); set_op(1'b1, 32'h8000_0008, 4'hF, 32'd2, 1'b1, 1'b1, 1'b1, '0);
    @(negedge clk); chk("st3_req", {31'd0, data_req}, 32'd0); chk("st3_stall", {31'd0, stallM}, 32'd1);
    chk("st3_pend", 32'(pend_dbg), 32'd2);
    step();
    @(negedge clk); chk("st3_req_b", {31'd0, data_req}, 32'd0);
    step(); man_dok = 1'b1;
    @(negedge clk); chk("st3_dok_req", {31'd0, data_req}, 32'd0); chk("st3_dok_stall", {31'd0, stallM}, 32'd1);
    step(); man_dok = 1'b0;
    @(negedge clk); chk("st3_issue", {31'd0, data_req}, 32'd1); chk("st3_release", {31'd0, stallM}, 32'd0);
    chk("st3_pend1", 32'(pend_dbg), 32'd1);
    step(); memenM = 1'b0;
    @(negedge clk); chk("st_pend2", 32'(pend_dbg), 32'd2);
    step(); man_dok = 1'b1;
    step();
    step(); man_dok = 1'b0;
    @(negedge clk); chk("st_drained", 32'(pend_dbg), 32'd0);

    // Load behind a pending store.
    step(); set_op(1'b1, 32'h8000_0014, 4'hF, 32'h1, 1'b1, 1'b1, 1'b1, '0);
    @(negedge clk); chk("sl_st_req", {31'd0, data_req}, 32'd1);
    step(); set_op(1'b0, 32'h8000_0014, 4'hF, '0, 1'b1, 1'b1, 1'b1, '0);
    exp_q.push_back(32'hCAFE_F00D); chk_load = 1'b1;
    @(negedge clk); chk("sl_wait_req", {31'd0, data_req}, 32'd0); chk("sl_pend", 32'(pend_dbg), 32'd1);
    chk("sl_wait_stall", {31'd0, stallM}, 32'd1);
    step(); man_dok = 1'b1;
    @(negedge clk); chk("sl_dok_req", {31'd0, data_req}, 32'd0);
    step(); man_dok = 1'b0;
    @(negedge clk); chk("sl_issue", {31'd0, data_req}, 32'd1); chk("sl_pend0", 32'(pend_dbg), 32'd0);
    step(); man_aok = 1'b0; man_dok = 1'b1; man_rdata = 32'hCAFE_F00D;
    @(negedge clk); chk("sl_lwait", 32'(state_dbg), 32'd2);
    step(); chk_load = 1'b0; memenM = 1'b0; man_dok = 1'b0;
    @(negedge clk); chk("sl_hold", readdataM, 32'hCAFE_F00D);

    // TLB exception table.
    man_aok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      set_op(tm_wr[i], 32'h8000_0000, 4'hF, '0, tm_f[i], tm_v[i], tm_d[i], tm_ein[i]);
      memenM = tm_men[i];
      @(negedge clk);
      chk("tlb_tab", 32'(tlb_except2M), 32'(exp_tlb(tm_men[i], tm_wr[i], tm_f[i], tm_v[i], tm_d[i], tm_ein[i])));
      chk("tlb_quiet", {30'd0, stallM, data_req}, 32'd0);
    end
    step(); memenM = 1'b0; tlb_exceptM = '0; data_found = 1'b1; data_V_flag = 1'b1; data_D_flag = 1'b1;
    @(negedge clk); chk("tlb_pend", 32'(pend_dbg), 32'd0);

    // Flush while waiting for load data.
    step(); set_op(1'b0, 32'h8000_0008, 4'hF, '0, 1'b1, 1'b1, 1'b1, '0);
    @(negedge clk); chk("fl_req", {31'd0, data_req}, 32'd1);
    step(); man_aok = 1'b0; flushM = 1'b1;
    @(negedge clk); chk("fl_stall", {31'd0, stallM}, 32'd0); chk("fl_req0", {31'd0, data_req}, 32'd0);
    step(); flushM = 1'b0; set_op(1'b0, 32'h8000_000C, 4'hF, '0, 1'b1, 1'b1, 1'b1, '0);
    @(negedge clk); chk("fl_drain", 32'(state_dbg), 32'd3); chk("fl_drain_stall", {31'd0, stallM}, 32'd1);
    chk("fl_drain_req", {31'd0, data_req}, 32'd0);
    step(); man_dok = 1'b1; man_rdata = 32'h0000_1234;
    @(negedge clk); chk("fl_discard", readdataM, 32'hCAFE_F00D); chk("fl_dok_req", {31'd0, data_req}, 32'd0);
    step(); man_dok = 1'b0;
    @(negedge clk); chk("fl_keep", readdataM, 32'hCAFE_F00D); chk("fl_idle", 32'(state_dbg), 32'd0);
    chk("fl_pend", 32'(pend_dbg), 32'd0); chk("fl_reissue", {31'd0, data_req}, 32'd1);
    step(); memenM = 1'b0;
    step();
    @(negedge clk); chk("fl_idle2", 32'(state_dbg), 32'd0);

    // Asynchronous reset with a store pending and a load waiting.
    step(); man_aok = 1'b1; set_op(1'b1, 32'h8000_0018, 4'hF, 32'h7, 1'b1, 1'b1, 1'b1, '0);
    @(negedge clk); chk("rs_st_req", {31'd0, data_req}, 32'd1);
    step(); set_op(1'b0, 32'h8000_0018, 4'hF, '0, 1'b1, 1'b1, 1'b1, '0);
    @(negedge clk); chk("rs_pend1", 32'(pend_dbg), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rs_stall", {31'd0, stallM}, 32'd0); chk("rs_req", {31'd0, data_req}, 32'd0);
    chk("rs_rdata", readdataM, 32'd0); chk("rs_pend", 32'(pend_dbg), 32'd0);
    chk("rs_state", 32'(state_dbg), 32'd0);
    step(); rst = 1'b1;
    @(negedge clk); chk("rs_new_req", {31'd0, data_req}, 32'd1);
    step(); man_aok = 1'b0; man_dok = 1'b1; man_rdata = 32'h5555_AAAA;
    exp_q.push_back(32'h5555_AAAA); chk_load = 1'b1;
    @(negedge clk);
    step(); chk_load = 1'b0; memenM = 1'b0; man_dok = 1'b0;

    // Random phase against the reference memory.
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      bus_mem[i] = ref_mem[i];
    end
    auto_bus = 1'b1;
    step();
    for (int n = 0; n < 300; n++) begin
      logic [EW-1:0] ein;
      ein = ($urandom_range(0, 15) == 0) ? EW'($urandom_range(1, 31)) : '0;
      run_op($urandom_range(0, 1) == 1, $urandom_range(0, 15), 4'($urandom_range(1, 15)), $urandom,
             $urandom_range(0, 19) != 0, $urandom_range(0, 19) != 0, $urandom_range(0, 9) != 0, ein);
      repeat ($urandom_range(0, 2)) step();
    end
    budget = 0;
    while (bq_ld.size() > 0 && budget < 200) begin
      step();
      budget++;
    end
    step();
    @(negedge clk);
    chk("end_bus_empty", 32'(bq_ld.size()), 32'd0);
    chk("end_pend", 32'(pend_dbg), 32'd0);
    chk("end_state", 32'(state_dbg), 32'd0);
    chk("end_exp_q", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
